adiabatic_pclk_gen: RTL and testbench
=====================================

# adiabatic_pclk_gen

Four-phase trapezoidal power-clock generator for the adiabatic ALU datapath. It produces the `clkpos`/`clkneg` rail pairs that the adiabatic cells (muxes, buffers, gates) consume. Alongside them it produces a digital ramp-level code per phase, for the verification models. It sits at the top of the ALU and feeds every adiabatic stage: phase *i* drives pipeline stage *i* mod 4.

## Interface

Parameters:
- `QUARTER_CYCLES`, default 8: clk cycles per stage (ramp-up, hold, ramp-down, wait); legal range ≥2.
- `CNT_W`, default `$clog2(QUARTER_CYCLES+1)`: width of the stage counter and the level code.

Ports:
- `clk` input 1: single system clock; all state changes on the rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `en` input 1: run request; level-sensitive.
- `clkpos` output 4: per-phase positive power-clock rail; high only in HOLD.
- `clkneg` output 4: per-phase complement rail, equal to `~clkpos` at all times.
- `level` output 4×CNT_W: per-phase ramp code, 0..QUARTER_CYCLES.
- `stage` output 4×2: per-phase stage encoding (0 WAIT, 1 RAMP_UP, 2 HOLD, 3 RAMP_DOWN).
- `period_start` output 1: one-cycle pulse when phase 0 enters RAMP_UP.
- `idle` output 1: high when all four phases are parked in WAIT and no start is pending.

## Operation

- Master state is a stage counter `cnt` (0..QUARTER_CYCLES-1) and a 2-bit master quarter `q`.
  - `cnt` wraps to 0 and `q` increments mod 4 each time `cnt` reaches QUARTER_CYCLES-1.
- Each phase *i* holds a `running` bit.
  - Its stage is `(q - i) mod 4` mapped 0→RAMP_UP, 1→HOLD, 2→RAMP_DOWN, 3→WAIT while `running`.
  - Its stage is WAIT when not `running`.
- Level per phase:
  - RAMP_UP = `cnt+1`.
  - HOLD = QUARTER_CYCLES.
  - RAMP_DOWN = QUARTER_CYCLES-1-`cnt`.
  - WAIT = 0.
- `clkpos[i]` = (stage == HOLD); `clkneg[i]` = ~`clkpos[i]`.
- Start:
  - With `idle` high, `en` sampled high forces `q`=0, `cnt`=0, and sets `running[0]` on that edge.
  - Phase *i* sets `running` at the boundary where its stage would become RAMP_UP, provided `en` is still high.
- Stop:
  - On a phase's RAMP_UP boundary, if `en` is low, that phase clears `running` and parks in WAIT.
  - A phase already past RAMP_UP always completes RAMP_DOWN; no rail ever drops from HOLD directly to WAIT.
- After `en` falls, `idle` rises once the last running phase finishes its RAMP_DOWN and reaches its RAMP_UP boundary.
  - While idle, `cnt` and `q` freeze at 0.
- `en` toggling mid-period is sampled only at each phase's RAMP_UP boundary; glitches between boundaries have no effect.

## Timing

- Reset (`rstn` low, asynchronous):
  - `cnt`=0, `q`=0, all `running`=0.
  - `clkpos`=4'b0000, `clkneg`=4'b1111, all `level`=0, all `stage`=WAIT.
  - `period_start`=0, `idle`=1.
  - Reset asserted mid-ramp forces these values immediately, without waiting for a clock edge.
- Start latency: `en` high at edge N gives phase 0 stage RAMP_UP and `level[0]`=1 after edge N, and `period_start` high for that one cycle.
  - Phase *i* begins RAMP_UP i×QUARTER_CYCLES cycles after phase 0.
- Period: 4×QUARTER_CYCLES cycles. `clkpos[i]` is high for exactly QUARTER_CYCLES consecutive cycles per period.
- Overlap: adjacent phases are offset by one quarter. `clkpos[i]` and `clkpos[(i+1) mod 4]` are never high in the same cycle.
- Wrap: `q` 3→0 is seamless; `period_start` pulses on every wrap while phase 0 keeps running.

## Structure

- Shared package `adiabatic_pkg` holds:
  - the `pclk_stage_e` enum (WAIT, RAMP_UP, HOLD, RAMP_DOWN) with the encoding above;
  - the `NUM_PHASES`=4 constant.
- One sub-module, `pclk_phase`, instantiated 4 times. It takes `q`, `cnt`, phase index and `en`, and holds `running`, decodes the stage and produces `level`, `clkpos` and `clkneg`.
- The top level owns `cnt`, `q`, `idle` and `period_start`.

## Test plan

- Reset: hold `rstn` low mid-run with QUARTER_CYCLES=8 → outputs at reset values asynchronously, `clkneg`=4'hF, `idle`=1.
- Start: `en` high for 64 cycles → phase 0 `level` sequence 1..8, 8×8, 7..0, 0×8; phase 1 identical, delayed 8 cycles; `period_start` every 32 cycles.
- Exclusivity: run 10 periods → `clkpos` one-hot or zero on every cycle, and `clkneg`==`~clkpos` on every cycle.
- Stop: drop `en` during phase 0 HOLD of period 2 → phase 0 completes RAMP_DOWN and parks; phases 1–3 each finish their in-flight cycle; `idle` rises; no `clkpos` rises afterward.
- Boundary glitch: pulse `en` low for 1 cycle away from any RAMP_UP boundary → waveform identical to an uninterrupted run.
- Parameter: QUARTER_CYCLES=2 → period 8 cycles, `level[0]` = 1,2,2,2,1,0,0,0 repeating.

Source files
------------

// File: rtl/adiabatic_pclk_gen_pkg.sv
// Shared types for the four-phase trapezoidal power-clock generator.
package adiabatic_pkg;

    localparam int NUM_PHASES = 4;

    typedef enum logic [1:0] {
        WAIT      = 2'd0,
        RAMP_UP   = 2'd1,
        HOLD      = 2'd2,
        RAMP_DOWN = 2'd3
    } pclk_stage_e;

    // Maps a running phase's quarter offset from the master quarter onto its stage.
    function automatic pclk_stage_e quarter_to_stage(input logic [1:0] rel);
        pclk_stage_e stg;
        case (rel)
            2'd0:    stg = RAMP_UP;
            2'd1:    stg = HOLD;
            2'd2:    stg = RAMP_DOWN;
            default: stg = WAIT;
        endcase
        return stg;
    endfunction

endpackage

// File: rtl/adiabatic_pclk_gen_if.sv
// Run request in, power-clock rails and per-phase ramp status out.
interface adiabatic_pclk_gen_if
    import adiabatic_pkg::*;
#(
    parameter int CNT_W = 4
);
    logic                                en;
    logic [NUM_PHASES-1:0]               clkpos;
    logic [NUM_PHASES-1:0]               clkneg;
    logic [NUM_PHASES-1:0][CNT_W-1:0]    level;
    logic [NUM_PHASES-1:0][1:0]          stage;
    logic                                period_start;
    logic                                idle;

    modport master (
        input  en,
        output clkpos, clkneg, level, stage, period_start, idle
    );

    modport slave (
        output en,
        input  clkpos, clkneg, level, stage, period_start, idle
    );
endinterface

// File: rtl/adiabatic_pclk_gen_phase.sv
// One power-clock phase: run flag, stage decode and registered rail/level outputs.
module pclk_phase
    import adiabatic_pkg::*;
#(
    parameter int QUARTER_CYCLES = 8,
    parameter int CNT_W          = $clog2(QUARTER_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [1:0]       phase_i,
    input  logic             en_i,
    input  logic             start_i,
    input  logic             wrap_i,
    input  logic [1:0]       q_i,
    input  logic [1:0]       q_d_i,
    input  logic [CNT_W-1:0] cnt_d_i,
    output logic             running_d_o,
    output logic [1:0]       stage_o,
    output logic [CNT_W-1:0] level_o,
    output logic             clkpos_o,
    output logic             clkneg_o
);

    localparam logic [CNT_W-1:0] LVL_FULL = CNT_W'(QUARTER_CYCLES);
    localparam logic [CNT_W-1:0] LVL_ONE  = CNT_W'(1);

    logic             running_q, running_d;
    pclk_stage_e      stage_q, stage_d;
    logic [CNT_W-1:0] level_q, level_d;
    logic             clkpos_q, clkpos_d;
    logic             clkneg_q;
    logic             boundary_s;

    // en only matters on the edge where this phase would re-enter RAMP_UP.
    assign boundary_s = wrap_i & ((q_i + 2'd1) == phase_i);

    // Next run flag, then the stage/level the phase shows after this edge.
    always_comb begin
        running_d = running_q;
        stage_d   = WAIT;
        level_d   = '0;
        if (start_i) begin
            running_d = (phase_i == 2'd0);
        end else if (boundary_s) begin
            running_d = en_i;
        end else begin
            running_d = running_q;
        end

        if (running_d) begin
            stage_d = quarter_to_stage(q_d_i - phase_i);
        end else begin
            stage_d = WAIT;
        end

        case (stage_d)
            RAMP_UP:   level_d = cnt_d_i + LVL_ONE;
            HOLD:      level_d = LVL_FULL;
            RAMP_DOWN: level_d = LVL_FULL - LVL_ONE - cnt_d_i;
            default:   level_d = '0;
        endcase
        clkpos_d = (stage_d == HOLD);
    end

    // Phase state and rail registers; rails come straight from flops.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            running_q <= 1'b0;
            stage_q   <= WAIT;
            level_q   <= '0;
            clkpos_q  <= 1'b0;
            clkneg_q  <= 1'b1;
        end else begin
            running_q <= running_d;
            stage_q   <= stage_d;
            level_q   <= level_d;
            clkpos_q  <= clkpos_d;
            clkneg_q  <= ~clkpos_d;
        end
    end

    assign running_d_o = running_d;
    assign stage_o     = stage_q;
    assign level_o     = level_q;
    assign clkpos_o    = clkpos_q;
    assign clkneg_o    = clkneg_q;

endmodule

// File: rtl/adiabatic_pclk_gen.sv
// Four-phase trapezoidal power-clock generator: master quarter/stage counter plus four phases.
module adiabatic_pclk_gen
    import adiabatic_pkg::*;
#(
    parameter int QUARTER_CYCLES = 8,
    parameter int CNT_W          = $clog2(QUARTER_CYCLES + 1)
) (
    input  logic                 clk,
    input  logic                 rstn,
    adiabatic_pclk_gen_if.master bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUARTER_CYCLES - 1);

    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [1:0]                       q_q, q_d;
    logic                             idle_q, idle_d;
    logic                             period_start_q, period_start_d;
    logic                             start_s, wrap_s;
    logic [NUM_PHASES-1:0]            running_d;
    logic [NUM_PHASES-1:0]            clkpos_s, clkneg_s;
    logic [NUM_PHASES-1:0][CNT_W-1:0] level_s;
    logic [NUM_PHASES-1:0][1:0]       stage_s;

    assign start_s = idle_q & bus.en;
    assign wrap_s  = ~idle_q & (cnt_q == CNT_LAST);

    // Master counter advance; once every phase has parked the counter freezes at zero.
    always_comb begin
        cnt_d          = cnt_q;
        q_d            = q_q;
        idle_d         = ~(|running_d);
        period_start_d = 1'b0;
        if (start_s) begin
            cnt_d          = '0;
            q_d            = 2'd0;
            period_start_d = 1'b1;
        end else if (idle_d) begin
            cnt_d = '0;
            q_d   = 2'd0;
        end else if (wrap_s) begin
            cnt_d          = '0;
            q_d            = q_q + 2'd1;
            period_start_d = (q_q == 2'd3) & running_d[0];
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Master state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q          <= '0;
            q_q            <= 2'd0;
            idle_q         <= 1'b1;
            period_start_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            q_q            <= q_d;
            idle_q         <= idle_d;
            period_start_q <= period_start_d;
        end
    end

    for (genvar g = 0; g < NUM_PHASES; g++) begin : g_phase
        pclk_phase #(
            .QUARTER_CYCLES (QUARTER_CYCLES),
            .CNT_W          (CNT_W)
        ) u_phase (
            .clk         (clk),
            .rstn        (rstn),
            .phase_i     (2'(g)),
            .en_i        (bus.en),
            .start_i     (start_s),
            .wrap_i      (wrap_s),
            .q_i         (q_q),
            .q_d_i       (q_d),
            .cnt_d_i     (cnt_d),
            .running_d_o (running_d[g]),
            .stage_o     (stage_s[g]),
            .level_o     (level_s[g]),
            .clkpos_o    (clkpos_s[g]),
            .clkneg_o    (clkneg_s[g])
        );
    end

    assign bus.clkpos       = clkpos_s;
    assign bus.clkneg       = clkneg_s;
    assign bus.level        = level_s;
    assign bus.stage        = stage_s;
    assign bus.period_start = period_start_q;
    assign bus.idle         = idle_q;

endmodule

// File: tb/tb_adiabatic_pclk_gen.sv
// Bench for adiabatic_pclk_gen: startup table, per-cycle reference model, stop/glitch/reset corners, QC=2 pattern.
module tb_adiabatic_pclk_gen;
    import adiabatic_pkg::*;

    localparam int QC  = 8;
    localparam int P   = 4 * QC;
    localparam int W1  = $clog2(QC + 1);
    localparam int QC2 = 2;
    localparam int W2  = $clog2(QC2 + 1);

    logic clk = 1'b0;
    logic rstn;
    int   n_total = 0;
    int   n_bad   = 0;

    // Reference model: time within the period and per-phase run flags.
    int         m_t;
    logic [3:0] m_run;
    logic       m_ps;

    typedef struct {
        logic en;
        int   lvl0;
        int   stg0;
        logic ps;
        logic idle;
    } vec_t;
    vec_t vecs [12];
    int   pat2 [8];

    adiabatic_pclk_gen_if #(.CNT_W(W1)) bus1 ();
    adiabatic_pclk_gen_if #(.CNT_W(W2)) bus2 ();

    adiabatic_pclk_gen #(.QUARTER_CYCLES(QC), .CNT_W(W1)) dut1 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus1)
    );

    adiabatic_pclk_gen #(.QUARTER_CYCLES(QC2), .CNT_W(W2)) dut2 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus2)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_t   = 0;
        m_run = 4'b0000;
        m_ps  = 1'b0;
    endtask

    // One clock edge of the spec rules, given the en value sampled on that edge.
    task automatic model_step(input logic e);
        int nt;
        if (m_run == 4'b0000) begin
            m_t  = 0;
            m_ps = e;
            if (e) m_run = 4'b0001;
        end else begin
            nt   = (m_t + 1) % P;
            m_ps = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (nt == i * QC) begin
                    m_run[i] = e;
                    if (i == 0) m_ps = e;
                end
            end
            if (m_run == 4'b0000) nt = 0;
            m_t = nt;
        end
    endtask

    task automatic model_check();
        logic [3:0]          e_pos;
        logic [3:0]          e_neg;
        logic [3:0][W1-1:0]  e_lvl;
        logic [3:0][1:0]     e_stg;
        int                  p;
        for (int i = 0; i < 4; i++) begin
            p        = (m_t - i * QC + P) % P;
            e_lvl[i] = '0;
            e_stg[i] = 2'd0;
            if (m_run[i]) begin
                case (p / QC)
                    0: begin e_stg[i] = 2'd1; e_lvl[i] = W1'(p % QC + 1);      end
                    1: begin e_stg[i] = 2'd2; e_lvl[i] = W1'(QC);              end
                    2: begin e_stg[i] = 2'd3; e_lvl[i] = W1'(QC - 1 - p % QC); end
                    default: begin e_stg[i] = 2'd0; e_lvl[i] = '0;             end
                endcase
            end
            e_pos[i] = (e_stg[i] == 2'd2);
        end
        e_neg = ~e_pos;
        chk("clkpos", 32'(bus1.clkpos), 32'(e_pos));
        chk("clkneg", 32'(bus1.clkneg), 32'(e_neg));
        chk("level", 32'(bus1.level), 32'(e_lvl));
        chk("stage", 32'(bus1.stage), 32'(e_stg));
        chk("period_start", 32'(bus1.period_start), 32'(m_ps));
        chk("idle", 32'(bus1.idle), 32'(m_run == 4'b0000));
        chk("excl", 32'((bus1.clkpos & (bus1.clkpos - 4'd1)) == 4'd0), 32'd1);
    endtask

    // Called at a negedge; drives en, takes one rising edge, checks at the next negedge.
    task automatic cycle(input logic e1, input logic e2);
        bus1.en = e1;
        bus2.en = e2;
        @(posedge clk);
        model_step(e1);
        @(negedge clk);
        model_check();
    endtask

    initial begin
        logic e;
        int   k;

        vecs[0] = '{1'b0, 0, 0, 1'b0, 1'b1};
        for (int i = 1; i <= 8; i++) vecs[i] = '{1'b1, i, 1, (i == 1), 1'b0};
        vecs[9]  = '{1'b1, 8, 2, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 8, 2, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 8, 2, 1'b0, 1'b0};
        pat2 = '{1, 2, 2, 2, 1, 0, 0, 0};

        rstn    = 1'b0;
        bus1.en = 1'b0;
        bus2.en = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        model_check();

        // Startup table, including a one-cycle en dip inside HOLD.
        for (int i = 0; i < 12; i++) begin
            cycle(vecs[i].en, 1'b0);
            chk("tbl_lvl0", 32'(bus1.level[0]), 32'(vecs[i].lvl0));
            chk("tbl_stg0", 32'(bus1.stage[0]), 32'(vecs[i].stg0));
            chk("tbl_ps", 32'(bus1.period_start), 32'(vecs[i].ps));
            chk("tbl_idle", 32'(bus1.idle), 32'(vecs[i].idle));
        end

        repeat (10 * P) cycle(1'b1, 1'b0);

        // Stop during phase 0 HOLD.
        for (k = 0; k < P && !(m_t >= QC && m_t < 2 * QC); k++) cycle(1'b1, 1'b0);
        for (k = 0; k < 6 * P && bus1.idle !== 1'b1; k++) cycle(1'b0, 1'b0);
        chk("stop_idle", 32'(bus1.idle), 32'd1);
        repeat (40) begin
            cycle(1'b0, 1'b0);
            chk("parked", 32'(bus1.clkpos), 32'd0);
        end

        // Single-cycle en glitch away from any RAMP_UP boundary.
        repeat (P + 5) cycle(1'b1, 1'b0);
        for (k = 0; k < P && (m_t % QC) != 3; k++) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        repeat (2 * P) cycle(1'b1, 1'b0);
        chk("glitch_all_run", 32'(m_run), 32'hF);

        // Asynchronous reset mid-ramp.
        repeat (13) cycle(1'b1, 1'b0);
        #1;
        rstn    = 1'b0;
        bus1.en = 1'b0;
        #1;
        chk("arst_clkpos", 32'(bus1.clkpos), 32'h0);
        chk("arst_clkneg", 32'(bus1.clkneg), 32'hF);
        chk("arst_level", 32'(bus1.level), 32'h0);
        chk("arst_stage", 32'(bus1.stage), 32'h0);
        chk("arst_ps", 32'(bus1.period_start), 32'h0);
        chk("arst_idle", 32'(bus1.idle), 32'h1);
        model_reset();
        @(negedge clk);
        model_check();
        rstn = 1'b1;

        // Random en with occasional toggles.
        e = 1'b0;
        repeat (1500) begin
            if ($urandom_range(0, 19) == 0) e = ~e;
            cycle(e, 1'b0);
        end

        // QUARTER_CYCLES=2 instance: 8-cycle period.
        for (int i = 0; i < 24; i++) begin
            cycle(1'b0, 1'b1);
            chk("q2_lvl0", 32'(bus2.level[0]), 32'(pat2[i % 8]));
            chk("q2_ps", 32'(bus2.period_start), 32'((i % 8) == 0));
            chk("q2_excl", 32'((bus2.clkpos & (bus2.clkpos - 4'd1)) == 4'd0), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
